sm_acc_reg: RTL and testbench

SM_ACC_REG -- requirements
Module: sm_acc_reg

---
 rtl/sm_acc_reg.sv | 179 +++++++++++++++++
 tb/tb_sm_acc_reg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_acc_reg.sv
// Sign-magnitude accumulator with a three-state IDLE/EXEC/DONE sequencer.
// ADD/SUB rely on an external combinational sign-magnitude adder (add_a/add_b -> sum_in).
module sm_acc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op,
  input  logic [15:0] operand,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] sum_in,
  output logic [15:0] acc,
  output logic        done,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_NEG  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [15:0] r_opnd;
  logic [15:0] r_acc;
  logic [15:0] r_add_b;
  logic        r_ready;
  logic        r_done;
  logic        r_z;
  logic        r_n;
  logic        r_v;

  logic        w_hs;
  logic [15:0] w_add_b_next;
  logic        w_write;
  logic [15:0] w_result;
  logic        w_v_next;

  // Magnitude-zero values are always stored as +0.
  function automatic logic [15:0] f_norm(input logic [15:0] x);
    f_norm = (x[14:0] == 15'd0) ? 16'h0000 : x;
  endfunction

  function automatic logic [15:0] f_flip(input logic [15:0] x);
    f_flip = {~x[15], x[14:0]};
  endfunction

  function automatic logic [15:0] f_add_b(input logic [2:0] o, input logic [15:0] x);
    case (o)
      OP_ADD:  f_add_b = x;
      OP_SUB:  f_add_b = f_flip(x);
      default: f_add_b = 16'h0000;
    endcase
  endfunction

  function automatic logic f_ovf(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] w_mag;
    w_mag = {1'b0, a[14:0]} + {1'b0, b[14:0]};
    f_ovf = (a[15] == b[15]) && w_mag[15];
  endfunction

  assign w_hs         = op_valid && r_ready && (r_state == ST_IDLE);
  assign w_add_b_next = f_add_b(op, operand);

  // Result and overflow for the operation held in r_op.
  always_comb begin
    w_write  = 1'b0;
    w_result = r_acc;
    w_v_next = r_v;
    case (r_op)
      OP_LOAD: begin
        w_write  = 1'b1;
        w_result = f_norm(r_opnd);
        w_v_next = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        w_write  = 1'b1;
        w_result = f_norm(sum_in);
        w_v_next = f_ovf(r_acc, r_add_b);
      end
      OP_CLR: begin
        w_write  = 1'b1;
        w_result = 16'h0000;
        w_v_next = 1'b0;
      end
      OP_NEG: begin
        w_write  = 1'b1;
        w_result = f_norm(f_flip(r_acc));
        w_v_next = 1'b0;
      end
      OP_NOP: begin
        w_write  = 1'b0;
        w_result = r_acc;
        w_v_next = r_v;
      end
      default: begin
        w_write  = 1'b0;
        w_result = r_acc;
        w_v_next = r_v;
      end
    endcase
  end

  // Sequencer; add_b is captured with the op so it holds steady through EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= 3'd0;
      r_opnd  <= 16'h0000;
      r_acc   <= 16'h0000;
      r_add_b <= 16'h0000;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_z     <= 1'b1;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_hs) begin
            r_op    <= op;
            r_opnd  <= operand;
            r_add_b <= w_add_b_next;
            r_ready <= 1'b0;
            r_state <= ST_EXEC;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (w_write) begin
            r_acc <= w_result;
            r_z   <= (w_result == 16'h0000);
            r_n   <= w_result[15];
          end else begin
            r_acc <= r_acc;
          end
          r_v     <= w_v_next;
          r_done  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_ready = r_ready;
  assign add_a    = r_acc;
  assign add_b    = r_add_b;
  assign acc      = r_acc;
  assign done     = r_done;
  assign flag_z   = r_z;
  assign flag_n   = r_n;
  assign flag_v   = r_v;

endmodule

// File: tb/tb_sm_acc_reg.sv
// Scoreboard bench for sm_acc_reg; also models the external sign-magnitude adder.
module tb_sm_acc_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [15:0] operand;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] sum_in;
  logic [15:0] acc;
  logic        done;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] sb_q[$];
  logic [15:0] m_acc;
  logic        m_z, m_n, m_v;

  sm_acc_reg dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .operand(operand), .add_a(add_a), .add_b(add_b), .sum_in(sum_in),
    .acc(acc), .done(done), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Sign-magnitude add; equal magnitudes with opposite signs keep the sign of a.
  function automatic logic [15:0] sm_add(input logic [15:0] a, input logic [15:0] b);
    logic [14:0] m;
    if (a[15] == b[15]) begin
      m = a[14:0] + b[14:0];
      return {a[15], m};
    end else if (a[14:0] >= b[14:0]) begin
      m = a[14:0] - b[14:0];
      return {a[15], m};
    end else begin
      m = b[14:0] - a[14:0];
      return {b[15], m};
    end
  endfunction

  always_comb sum_in = sm_add(add_a, add_b);

  task automatic model_reset();
    m_acc = 16'h0000; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [2:0] o, input logic [15:0] x);
    logic [15:0] b;
    logic [15:0] r;
    int s;
    case (o)
      3'd1: begin m_acc = (x[14:0] == 15'd0) ? 16'h0000 : x; m_v = 1'b0; end
      3'd2, 3'd3: begin
        b = (o == 3'd2) ? x : {~x[15], x[14:0]};
        s = int'(m_acc[14:0]) + int'(b[14:0]);
        m_v = (m_acc[15] == b[15]) && (s >= 32768);
        r = sm_add(m_acc, b);
        m_acc = (r[14:0] == 15'd0) ? 16'h0000 : r;
      end
      3'd4: begin m_acc = 16'h0000; m_v = 1'b0; end
      3'd5: begin
        m_acc = (m_acc[14:0] == 15'd0) ? 16'h0000 : {~m_acc[15], m_acc[14:0]};
        m_v = 1'b0;
      end
      default: ;
    endcase
    m_z = (m_acc == 16'h0000);
    m_n = m_acc[15];
    sb_q.push_back({m_acc, m_z, m_n, m_v});
  endtask

  // Drive an op from a negedge, wait for acceptance, return #1 after the handshake edge.
  task automatic send(input logic [2:0] o, input logic [15:0] x);
    int w = 0;
    op = o; operand = x; op_valid = 1'b1;
    while (!op_ready && w < 20) begin @(negedge clk); w++; end
    if (!op_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout op=%0d op_ready=%b required 1", o, op_ready);
    end
    @(posedge clk);
    model_step(o, x);
    #1 op_valid = 1'b0;
  endtask

  // Wait for done (bounded) and report what the DUT shows at that point.
  task automatic collect(output logic got, output logic [18:0] obs, output int lat);
    got = 1'b0; obs = 19'd0; lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done && !got) begin
        got = 1'b1; lat = i; obs = {acc, flag_z, flag_n, flag_v};
      end
      if (got) break;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({acc, flag_z, flag_n, flag_v, done, op_ready} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state acc=%h z=%b n=%b v=%b done=%b rdy=%b required 0000 1 0 0 0 1",
               acc, flag_z, flag_n, flag_v, done, op_ready);
    end
    n_cmp++;
    if (add_a !== 16'h0000 || add_b !== 16'h0000) begin
      n_bad++; $display("FAIL reset_adder add_a=%h add_b=%h required 0000 0000", add_a, add_b);
    end
  endtask

  task automatic test_load_add();
    logic got; logic [18:0] obs, exp; int lat;
    send(3'd1, 16'h0005); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load5 got=%h required %h", obs, exp); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load5_latency got=%0d required 2", lat); end
    send(3'd2, 16'h8003); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL add8003 got=%h required %h", obs, exp); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL add_latency got=%0d required 2", lat); end
    n_cmp++;
    if ({acc, flag_z, flag_n, flag_v} !== {16'h0002, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add_result acc=%h z=%b n=%b v=%b required 0002 0 0 0", acc, flag_z, flag_n, flag_v);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width done=%b required 0", done); end
  endtask

  task automatic test_sub();
    logic got; logic [18:0] obs, exp; int lat;
    send(3'd1, 16'h0003); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load3 got=%h required %h", obs, exp); end
    send(3'd3, 16'h0005);
    n_cmp++;
    if (add_b !== 16'h8005 || add_a !== 16'h0003) begin
      n_bad++; $display("FAIL sub_adder_ops add_a=%h add_b=%h required 0003 8005", add_a, add_b);
    end
    collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL sub5 got=%h required %h", obs, exp); end
    n_cmp++;
    if ({acc, flag_z, flag_n} !== {16'h8002, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL sub_result acc=%h z=%b n=%b required 8002 0 1", acc, flag_z, flag_n);
    end
  endtask

  task automatic test_overflow();
    logic got; logic [18:0] obs, exp; int lat;
    send(3'd1, 16'h7FFF); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load7fff got=%h required %h", obs, exp); end
    send(3'd2, 16'h0001); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL ovf_add got=%h required %h", obs, exp); end
    n_cmp++;
    if ({acc, flag_z, flag_v} !== {16'h0000, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL ovf_flags acc=%h z=%b v=%b required 0000 1 1", acc, flag_z, flag_v);
    end
    send(3'd0, 16'h1111); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL nop_keeps got=%h required %h", obs, exp); end
    send(3'd4, 16'h0000); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL clr got=%h required %h", obs, exp); end
    n_cmp++; if (flag_v !== 1'b0) begin n_bad++; $display("FAIL clr_clears_v v=%b required 0", flag_v); end
  endtask

  task automatic test_negzero();
    logic got; logic [18:0] obs, exp; int lat;
    send(3'd1, 16'h8000); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load8000 got=%h required %h", obs, exp); end
    n_cmp++;
    if ({acc, flag_z, flag_n} !== {16'h0000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL negzero_load acc=%h z=%b n=%b required 0000 1 0", acc, flag_z, flag_n);
    end
    send(3'd1, 16'h8001); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load8001 got=%h required %h", obs, exp); end
    send(3'd2, 16'h0001);
    n_cmp++; if (sum_in !== 16'h8000) begin n_bad++; $display("FAIL negzero_sum sum_in=%h required 8000", sum_in); end
    collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL negzero_add got=%h required %h", obs, exp); end
    n_cmp++; if (acc !== 16'h0000) begin n_bad++; $display("FAIL negzero_acc acc=%h required 0000", acc); end
  endtask

  task automatic test_neg_reserved();
    logic got; logic [18:0] obs, exp; int lat;
    send(3'd1, 16'h0007); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL load7 got=%h required %h", obs, exp); end
    send(3'd5, 16'h0000); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL neg got=%h required %h", obs, exp); end
    send(3'd6, 16'h2222); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL reserved6 got=%h required %h", obs, exp); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL reserved_done latency=%0d required 2", lat); end
    send(3'd7, 16'h3333); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL reserved7 got=%h required %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic got; logic [18:0] obs, exp; int lat;
    int acc_cnt = 0, done_cnt = 0, low_cnt = 0;
    send(3'd4, 16'h0000); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL b2b_clr got=%h required %h", obs, exp); end
    @(negedge clk);
    op = 3'd2; operand = 16'h0001; op_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (op_ready) begin acc_cnt++; model_step(3'd2, 16'h0001); end
      else low_cnt++;
      if (done) begin
        done_cnt++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h7FFFF;
        n_cmp++;
        if ({acc, flag_z, flag_n, flag_v} !== exp) begin
          n_bad++; $display("FAIL b2b_result got=%h required %h", {acc, flag_z, flag_n, flag_v}, exp);
        end
      end
      operand = op_ready ? 16'h0001 : 16'h0100;
      @(negedge clk);
    end
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    n_cmp++; if (acc_cnt !== 2) begin n_bad++; $display("FAIL b2b_accepts got=%0d required 2", acc_cnt); end
    n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_dones got=%0d required 2", done_cnt); end
    n_cmp++; if (low_cnt !== 4) begin n_bad++; $display("FAIL b2b_ready_low got=%0d required 4", low_cnt); end
    n_cmp++; if (acc !== 16'h0002) begin n_bad++; $display("FAIL b2b_acc acc=%h required 0002", acc); end
  endtask

  task automatic test_reset_mid();
    logic got; logic [18:0] obs, exp; int lat;
    int done_cnt = 0;
    send(3'd1, 16'h00AA); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL pre_reset_load got=%h required %h", obs, exp); end
    send(3'd1, 16'h1234);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({acc, flag_z, done, op_ready} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_mid acc=%h z=%b done=%b rdy=%b required 0000 1 0 1", acc, flag_z, done, op_ready);
    end
    model_reset();
    op = 3'd1; operand = 16'h5555; op_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (acc !== 16'h0000) begin n_bad++; $display("FAIL reset_no_accept acc=%h required 0000", acc); end
    reset = 1'b0; op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL reset_discard dones=%0d required 0", done_cnt); end
    n_cmp++;
    if (op_ready !== 1'b1 || acc !== 16'h0000) begin
      n_bad++; $display("FAIL post_reset rdy=%b acc=%h required 1 0000", op_ready, acc);
    end
    send(3'd1, 16'h0042); collect(got, obs, lat); exp = sb_q.pop_front();
    n_cmp++; if (!got || obs !== exp) begin n_bad++; $display("FAIL post_reset_load got=%h required %h", obs, exp); end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; operand = 16'h0000;
    model_reset();
    #1;
    test_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    test_load_add();
    test_sub();
    test_overflow();
    test_negzero();
    test_neg_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
